regfile_mp: RTL

Parametrised register file for the rvsimple pipelined core family, generalising the fixed 32x32, 2-read regfile.
- Configurable data width, register count and number of read ports.
- Optional hardwired zero register.
- Optional write-to-read bypass.
- Per-register busy scoreboard, so the decode stage can detect read-after-write hazards on in-flight writes.
- Synchronous reset-time clear sweep, so every register has a defined value.

---
 rtl/regfile_mp.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with a per-register busy scoreboard,
// optional hardwired zero register, optional write bypass and a reset-time clear sweep.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_READ = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [AW-1:0]              rd_address,
    input  logic [XLEN-1:0]            rd_data,
    input  logic                       reserve_enable,
    input  logic [AW-1:0]              reserve_address,
    input  logic [NUM_READ*AW-1:0]     rs_address,
    output logic [NUM_READ*XLEN-1:0]   rs_data,
    output logic [NUM_READ-1:0]        rs_busy,
    output logic                       ready
);

    typedef enum logic {StClear, StRun} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       clear_idx_q, clear_idx_d;
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW-1:0]       ra [NUM_READ];
    logic                wr_ok, rsv_ok;

    // True when the address names a real, writable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok  = (state_q == StRun) && write_enable && addr_ok(rd_address);
    assign rsv_ok = (state_q == StRun) && reserve_enable && addr_ok(reserve_address);
    assign ready  = (state_q == StRun);

    for (genvar g = 0; g < NUM_READ; g++) begin : g_ra
        assign ra[g] = rs_address[g*AW +: AW];
    end

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        regs_d      = regs_q;
        busy_d      = busy_q;
        case (state_q)
            StClear: begin
                regs_d[clear_idx_q] = '0;
                if (clear_idx_q == AW'(NUM_REGS - 1)) begin
                    state_d     = StRun;
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + 1'b1;
                end
            end
            StRun: begin
                if (wr_ok) begin
                    regs_d[rd_address] = rd_data;
                    busy_d[rd_address] = 1'b0;
                end
                // Reserve after write so a colliding reserve keeps the register busy.
                if (rsv_ok) begin
                    busy_d[reserve_address] = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StClear;
            clear_idx_q <= '0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if ((state_q == StRun) && addr_ok(ra[i])) begin
                if (BYPASS && wr_ok && (rd_address == ra[i])) begin
                    rs_data[i*XLEN +: XLEN] = rd_data;
                end else begin
                    rs_data[i*XLEN +: XLEN] = regs_q[ra[i]];
                    rs_busy[i]              = busy_q[ra[i]];
                end
            end
        end
    end

endmodule
